// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one 32-bit ALU between two valid/ready requesters using
//   round-robin arbitration. IDLE captures the winner's operands, EXEC
//   drives the ALU for exactly one cycle, and RESP holds the captured
//   result until the winning requester accepts it.
//   Build option: define ALU_SHARE_OPCHK_EN to reject illegal op codes
//   without touching the ALU; this also adds the resp_err port.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
`ifdef ALU_SHARE_OPCHK_EN
    output logic              resp_err,
`endif
    output logic [DATA_W-1:0] alu_src_a,
    output logic [DATA_W-1:0] alu_src_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q;   // port served by the most recent handshake
    logic                gnt_q;          // port currently being served
    logic [DATA_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   result_q;
    logic                zero_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                gnt_sel;
    logic                accept;
    logic                handshake;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [OP_W-1:0]     sel_op;

    // Round-robin choice: a lone requester wins, a tie goes to the port not served last
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt_sel = 1'b0;
        case (req_valid)
            2'b10:   gnt_sel = 1'b1;
            2'b11:   gnt_sel = ~last_grant_q;
            default: gnt_sel = 1'b0;
        endcase
    end

    assign sel_a  = gnt_sel ? req_a1  : req_a0;
    assign sel_b  = gnt_sel ? req_b1  : req_b0;
    assign sel_op = gnt_sel ? req_op1 : req_op0;

`ifdef ALU_SHARE_OPCHK_EN
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(3'b010);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3'b011);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(3'b110);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(3'b100);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3'b101);

    logic op_illegal;
    logic err_q;

    // Flag any op code outside the five the ALU implements
    always_comb begin
        op_illegal = 1'b1;
        case (sel_op)
            OP_ADD, OP_SUB, OP_SLT, OP_OR, OP_AND: op_illegal = 1'b0;
            default:                               op_illegal = 1'b1;
        endcase
    end

    assign resp_err = err_q;
`endif

    // Next-state and handshake outputs; req_ready is masked while reset is held
    always_comb begin
        state_d    = state_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && (req_valid != 2'b00)) begin
                    accept             = 1'b1;
                    req_ready[gnt_sel] = 1'b1;
`ifdef ALU_SHARE_OPCHK_EN
                    state_d = op_illegal ? RESP : EXEC;
`else
                    state_d = EXEC;
`endif
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                if (resp_ready[gnt_q]) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, round-robin pointer and saturating completion counter
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                last_grant_q <= gnt_q;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Operand capture at grant, result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_SHARE_OPCHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                gnt_q <= gnt_sel;
                a_q   <= sel_a;
                b_q   <= sel_b;
                op_q  <= sel_op;
`ifdef ALU_SHARE_OPCHK_EN
                err_q <= op_illegal;
                if (op_illegal) begin
                    result_q <= '0;
                    zero_q   <= 1'b1;
                end
`endif
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

    // The ALU only sees live operands during EXEC; otherwise its inputs stay quiet
    assign alu_src_a   = (state_q == EXEC) ? a_q  : '0;
    assign alu_src_b   = (state_q == EXEC) ? b_q  : '0;
    assign alu_ctrl    = (state_q == EXEC) ? op_q : '0;

    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign busy        = (state_q != IDLE);
    assign ops_done    = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter. A behavioural ALU stands in
//   for the shared ALU; expected results, grant order and latencies come from
//   plain arithmetic on the request operands and the round-robin rule.
//   Compile with ALU_SHARE_OPCHK_EN defined to exercise the op-check build.
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [OP_W-1:0]   req_op0, req_op1;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_result;
    logic              resp_zero;
`ifdef ALU_SHARE_OPCHK_EN
    logic              resp_err;
`endif
    logic [DATA_W-1:0] alu_src_a, alu_src_b, alu_result;
    logic [OP_W-1:0]   alu_ctrl;
    logic              alu_zero;
    logic              busy;
    logic [CNT_W-1:0]  ops_done;

    int errors  = 0;
    int checks  = 0;
    int exp_ops = 0;

    always #5 clk = ~clk;

    // Reference ALU behaviour taken straight from the op-code table
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b110:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a | b;
            3'b101:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

`ifdef ALU_SHARE_OPCHK_EN
    function automatic logic is_legal(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011) || (op == 3'b110) || (op == 3'b100) || (op == 3'b101);
    endfunction
`endif

    assign alu_result = ref_alu(alu_src_a, alu_src_b, alu_ctrl);
    assign alu_zero   = (alu_result == '0);

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
`ifdef ALU_SHARE_OPCHK_EN
        .resp_err(resp_err),
`endif
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .ops_done(ops_done)
    );

    // Drives one request on one port and returns what was observed; no judging here
    task automatic run_one(input logic port, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           output logic [31:0] res, output logic z, output logic e, output int lat,
                           output int rdy_cnt, output int ctrl_cnt, output logic [2:0] ctrl_seen, output logic to);
        int n;
        to = 1'b0; res = '0; z = 1'b0; e = 1'b0; lat = 0; rdy_cnt = 0; ctrl_cnt = 0; ctrl_seen = 3'b000;
        @(negedge clk);
        if (port == 1'b0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
        else begin req_a1 = a; req_b1 = b; req_op1 = op; end
        req_valid[port] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[port] && n < 50) begin @(negedge clk); #1; n++; end
        if (!req_ready[port]) begin to = 1'b1; req_valid[port] = 1'b0; return; end
        rdy_cnt = 1;
        @(negedge clk);
        req_valid[port] = 1'b0;
        #1;
        lat = 1;
        while (!resp_valid[port] && lat < 20) begin
            if (req_ready != 2'b00) rdy_cnt++;
            if (alu_ctrl != 3'b000) begin ctrl_cnt++; ctrl_seen = alu_ctrl; end
            @(negedge clk); #1; lat++;
        end
        if (!resp_valid[port]) begin to = 1'b1; return; end
        if (alu_ctrl != 3'b000) ctrl_cnt++;
        res = resp_result;
        z   = resp_zero;
`ifdef ALU_SHARE_OPCHK_EN
        e   = resp_err;
`endif
        resp_ready[port] = 1'b1;
        @(negedge clk);
        resp_ready[port] = 1'b0;
        exp_ops++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req_valid = 2'b00; resp_ready = 2'b00; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 0;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11; resp_ready = 2'b11;
        req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
        req_op0 = 3'b010; req_op1 = 3'b011;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
        checks++; if (resp_result !== 32'd0) begin errors++; $display("FAIL reset_resp_result got=%h exp=0", resp_result); end
        checks++; if (resp_zero !== 1'b0) begin errors++; $display("FAIL reset_resp_zero got=%b exp=0", resp_zero); end
        checks++; if (alu_src_a !== 32'd0 || alu_src_b !== 32'd0) begin errors++; $display("FAIL reset_alu_src got=%h/%h exp=0/0", alu_src_a, alu_src_b); end
        checks++; if (alu_ctrl !== 3'b000) begin errors++; $display("FAIL reset_alu_ctrl got=%b exp=000", alu_ctrl); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done got=%0d exp=0", ops_done); end
`ifdef ALU_SHARE_OPCHK_EN
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_contention got=%b exp=01", req_ready); end
        #1;
        req_valid = 2'b00; resp_ready = 2'b00;
    endtask

    task automatic test_single();
        logic [31:0] res; logic z, e, to; int lat, rc, cc; logic [2:0] cs;
        run_one(1'b0, 32'd5, 32'd3, 3'b010, res, z, e, lat, rc, cc, cs, to);
        #1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got=%b exp=0", to); end
        checks++; if (rc !== 1) begin errors++; $display("FAIL single_ready_pulses got=%0d exp=1", rc); end
        checks++; if (cc !== 1 || cs !== 3'b010) begin errors++; $display("FAIL single_alu_ctrl cycles=%0d ctrl=%b exp=1/010", cc, cs); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", lat); end
        checks++; if (res !== 32'd8 || z !== 1'b0) begin errors++; $display("FAIL single_result got=%h/%b exp=8/0", res, z); end
        checks++; if (ops_done !== CNT_W'(exp_ops)) begin errors++; $display("FAIL single_ops_done got=%0d exp=%0d", ops_done, exp_ops); end
    endtask

    task automatic test_sub_slt();
        logic [31:0] res; logic z, e, to; int lat, rc, cc; logic [2:0] cs;
        run_one(1'b1, 32'd7, 32'd7, 3'b011, res, z, e, lat, rc, cc, cs, to);
        checks++; if (to || res !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL sub_zero got=%h/%b to=%b exp=0/1", res, z, to); end
        run_one(1'b1, 32'd3, 32'd5, 3'b110, res, z, e, lat, rc, cc, cs, to);
        checks++; if (to || res !== 32'd1 || z !== 1'b0) begin errors++; $display("FAIL slt_less got=%h/%b to=%b exp=1/0", res, z, to); end
        run_one(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b110, res, z, e, lat, rc, cc, cs, to);
        checks++; if (to || res !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL slt_unsigned got=%h/%b to=%b exp=0/1", res, z, to); end
    endtask

    task automatic test_contention();
        logic gp[$]; logic rp[$]; logic [31:0] rr[$]; int gcyc[$];
        logic exp_g[3]; logic last; int cyc; logic overlap;
        apply_reset();
        last = 1'b1;
        for (int i = 0; i < 3; i++) begin exp_g[i] = ~last; last = exp_g[i]; end
        @(negedge clk);
        req_a0 = 32'hF0; req_b0 = 32'h3C; req_op0 = 3'b100;
        req_a1 = 32'hF0; req_b1 = 32'h3C; req_op1 = 3'b101;
        req_valid = 2'b11; resp_ready = 2'b11;
        cyc = 0; overlap = 1'b0;
        #1;
        while (rp.size() < 3 && cyc < 40) begin
            if (req_ready == 2'b11 || resp_valid == 2'b11) overlap = 1'b1;
            if (req_ready == 2'b01) begin gp.push_back(1'b0); gcyc.push_back(cyc); end
            else if (req_ready == 2'b10) begin gp.push_back(1'b1); gcyc.push_back(cyc); end
            if (resp_valid == 2'b01) begin rp.push_back(1'b0); rr.push_back(resp_result); end
            else if (resp_valid == 2'b10) begin rp.push_back(1'b1); rr.push_back(resp_result); end
            if (rp.size() < 3) begin @(negedge clk); #1; cyc++; end
        end
        @(negedge clk);
        req_valid = 2'b00; resp_ready = 2'b00;
        exp_ops += rp.size();
        #1;
        checks++; if (gp.size() != 3 || rp.size() != 3) begin errors++; $display("FAIL contention_count grants=%0d resps=%0d exp=3/3", gp.size(), rp.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gp[i] !== exp_g[i] || rp[i] !== exp_g[i] || rr[i] !== ref_alu(32'hF0, 32'h3C, exp_g[i] ? 3'b101 : 3'b100)) begin
                    errors++;
                    $display("FAIL contention_txn%0d grant=%b resp=%b result=%h exp port=%b result=%h", i, gp[i], rp[i], rr[i], exp_g[i], ref_alu(32'hF0, 32'h3C, exp_g[i] ? 3'b101 : 3'b100));
                end
            end
            checks++; if (gcyc[1] - gcyc[0] != 3 || gcyc[2] - gcyc[1] != 3) begin errors++; $display("FAIL contention_spacing got=%0d,%0d exp=3,3", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]); end
        end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL contention_onehot got=1 exp=0"); end
        checks++; if (ops_done !== CNT_W'(exp_ops)) begin errors++; $display("FAIL contention_ops_done got=%0d exp=%0d", ops_done, exp_ops); end
    endtask

    task automatic test_backpressure();
        int n, bad; logic [31:0] held; logic hz, acc;
        @(negedge clk);
        req_a0 = 32'h1234_5678; req_b0 = 32'h1111_1111; req_op0 = 3'b010;
        req_valid = 2'b01; resp_ready = 2'b10;
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept0 got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        req_a1 = 32'h10; req_b1 = 32'h20; req_op1 = 3'b110;
        req_valid = 2'b10;
        #1;
        bad = 0; n = 0;
        while (!resp_valid[0] && n < 10) begin
            if (req_ready != 2'b00 || busy !== 1'b1) bad++;
            @(negedge clk); #1; n++;
        end
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL bp_resp_valid got=%b exp=01", resp_valid); end
        held = resp_result; hz = resp_zero;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 2'b01 || resp_result !== held || resp_zero !== hz || req_ready !== 2'b00 || busy !== 1'b1) bad++;
            @(negedge clk); #1;
        end
        checks++; if (held !== ref_alu(32'h1234_5678, 32'h1111_1111, 3'b010) || hz !== 1'b0) begin errors++; $display("FAIL bp_result got=%h/%b exp=%h/0", held, hz, ref_alu(32'h1234_5678, 32'h1111_1111, 3'b010)); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall_stability bad_cycles=%0d exp=0", bad); end
        checks++; if (resp_valid !== 2'b01 || resp_result !== held) begin errors++; $display("FAIL bp_still_held got=%b/%h exp=01/%h", resp_valid, resp_result, held); end
        resp_ready = 2'b11;
        @(negedge clk); #1;
        exp_ops++;
        acc = (req_ready === 2'b10);
        checks++; if (!acc) begin errors++; $display("FAIL bp_pending_grant got=%b exp=10", req_ready); end
        checks++; if (ops_done !== CNT_W'(exp_ops)) begin errors++; $display("FAIL bp_ops_done got=%0d exp=%0d", ops_done, exp_ops); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n = 0;
        while (!resp_valid[1] && n < 10) begin @(negedge clk); #1; n++; end
        checks++; if (resp_valid !== 2'b10 || resp_result !== 32'd1 || resp_zero !== 1'b0) begin errors++; $display("FAIL bp_port1_resp got=%b/%h/%b exp=10/1/0", resp_valid, resp_result, resp_zero); end
        @(negedge clk);
        resp_ready = 2'b00;
        exp_ops++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic z, e, to; int lat, rc, cc; logic [2:0] cs; logic stray;
        run_one(1'b0, 32'd1, 32'd2, 3'b010, res, z, e, lat, rc, cc, cs, to);
        @(negedge clk);
        req_a1 = 32'd9; req_b1 = 32'd4; req_op1 = 3'b011;
        req_valid = 2'b10; resp_ready = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rstmid_accept got=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++; if (alu_ctrl !== 3'b011 || alu_src_a !== 32'd9 || alu_src_b !== 32'd4) begin errors++; $display("FAIL rstmid_exec got=%b/%h/%h exp=011/9/4", alu_ctrl, alu_src_a, alu_src_b); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || req_ready !== 2'b00 || resp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_ctrl_outputs got=%b/%b/%b exp=0/00/00", busy, req_ready, resp_valid); end
        checks++; if (alu_src_a !== 32'd0 || alu_src_b !== 32'd0 || alu_ctrl !== 3'b000) begin errors++; $display("FAIL rstmid_alu_outputs got=%h/%h/%b exp=0/0/000", alu_src_a, alu_src_b, alu_ctrl); end
        checks++; if (resp_result !== 32'd0 || resp_zero !== 1'b0 || ops_done !== 16'd0) begin errors++; $display("FAIL rstmid_data_outputs got=%h/%b/%0d exp=0/0/0", resp_result, resp_zero, ops_done); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 0;
        stray = 1'b0;
        repeat (6) begin
            #1;
            if (resp_valid !== 2'b00 || busy !== 1'b0) stray = 1'b1;
            @(negedge clk);
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rstmid_no_response got=1 exp=0"); end
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 3'b010;
        req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = 3'b010;
        req_valid = 2'b11; resp_ready = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_pointer got=%b exp=01", req_ready); end
        #1;
        req_valid = 2'b00;
    endtask

    task automatic test_illegal();
        logic [31:0] res; logic z, e, to; int lat, rc, cc; logic [2:0] cs;
        run_one(1'b0, 32'hDEAD, 32'hBEEF, 3'b111, res, z, e, lat, rc, cc, cs, to);
        checks++; if (to || res !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL illegal_result got=%h/%b to=%b exp=0/1", res, z, to); end
`ifdef ALU_SHARE_OPCHK_EN
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
        checks++; if (cc !== 0) begin errors++; $display("FAIL illegal_alu_quiet cycles=%0d exp=0", cc); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b exp=1", e); end
        run_one(1'b1, 32'd2, 32'd2, 3'b011, res, z, e, lat, rc, cc, cs, to);
        checks++; if (to || e !== 1'b0 || lat !== 2 || z !== 1'b1) begin errors++; $display("FAIL legal_err_clear got err=%b lat=%0d zero=%b exp=0/2/1", e, lat, z); end
`else
        checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency got=%0d exp=2", lat); end
        checks++; if (cc !== 1 || cs !== 3'b111) begin errors++; $display("FAIL illegal_alu_ctrl cycles=%0d ctrl=%b exp=1/111", cc, cs); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, exp_r; logic z, e, to, port; int lat, rc, cc, exp_lat; logic [2:0] cs, op;
        for (int i = 0; i < 24; i++) begin
            port = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = 3'($urandom_range(0, 7));
            run_one(port, a, b, op, res, z, e, lat, rc, cc, cs, to);
            exp_r = ref_alu(a, b, op);
            exp_lat = 2;
`ifdef ALU_SHARE_OPCHK_EN
            if (!is_legal(op)) exp_lat = 1;
            checks++; if (e !== !is_legal(op)) begin errors++; $display("FAIL random%0d_err op=%b got=%b exp=%b", i, op, e, !is_legal(op)); end
`endif
            checks++;
            if (to || res !== exp_r || z !== (exp_r == 32'd0) || lat !== exp_lat || rc !== 1) begin
                errors++;
                $display("FAIL random%0d port=%b a=%h b=%h op=%b got=%h/%b lat=%0d rdy=%0d to=%b exp=%h/%b lat=%0d rdy=1", i, port, a, b, op, res, z, lat, rc, to, exp_r, (exp_r == 32'd0), exp_lat);
            end
        end
        #1;
        checks++; if (ops_done !== CNT_W'(exp_ops)) begin errors++; $display("FAIL random_ops_done got=%0d exp=%0d", ops_done, exp_ops); end
    endtask

    initial begin
        req_valid = 2'b00; resp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
        test_reset();
        test_single();
        test_sub_slt();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
